// File: rtl/move_queue.sv
// move_queue: assembles coordinated-move records from SPI words
// (0x01 header + duration, increment, incinc payload words) and queues them
// in a power-of-two FIFO. The stepper DDA executor reads them, oldest first,
// through a valid/ready handshake.
// The head record is held in a registered output stage, so a record becomes
// visible one clock after it is committed.
module move_queue #(
    parameter int BUFFER_BITS = 2,
    parameter int WORD_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   word_valid,
    input  logic [WORD_WIDTH-1:0]  word_data,
    input  logic                   word_is_header,
    output logic                   move_valid,
    input  logic                   move_ready,
    output logic                   move_dir,
    output logic [WORD_WIDTH-1:0]  move_duration,
    output logic [WORD_WIDTH-1:0]  move_increment,
    output logic [WORD_WIDTH-1:0]  move_incinc,
    output logic [BUFFER_BITS:0]   fill_count,
    output logic                   full,
    output logic                   collecting,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    localparam int DEPTH      = 1 << BUFFER_BITS;
    localparam int PTR_W      = BUFFER_BITS + 1;
    localparam int NUM_FIELDS = 3;
    // Pointer XOR pattern when the FIFO holds exactly DEPTH records.
    localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {BUFFER_BITS{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_W3   = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic move_hdr;
    logic payload;
    logic commit;

    logic                  dir_reg;
    logic [WORD_WIDTH-1:0] duration_reg;
    logic [WORD_WIDTH-1:0] increment_reg;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [BUFFER_BITS-1:0] wr_addr;
    logic [BUFFER_BITS-1:0] rd_addr_next;

    logic pop;
    logic push;
    logic full_int;
    logic head_valid_next;
    logic move_valid_reg;
    logic overflow_reg;

    logic                  dir_mem [DEPTH];
    logic                  dir_head_reg;
    logic [WORD_WIDTH-1:0] field_wr   [NUM_FIELDS];
    logic [WORD_WIDTH-1:0] field_head [NUM_FIELDS];

    // Word classification shared by the FSM and the field latches.
    assign move_hdr = word_valid & word_is_header &
                      (word_data[WORD_WIDTH-1 -: 8] == 8'h01);
    assign payload  = word_valid & ~word_is_header;

    // Assembly state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: any header restarts or abandons the message; payload
    // words advance through the three fields and are ignored when idle.
    always_comb begin
        state_next = state_reg;
        if (word_valid && word_is_header) begin
            state_next = move_hdr ? S_W1 : S_IDLE;
        end else if (payload) begin
            case (state_reg)
                S_W1:    state_next = S_W2;
                S_W2:    state_next = S_W3;
                S_W3:    state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs: message-in-progress flag and the record commit strobe.
    always_comb begin
        collecting = (state_reg != S_IDLE);
        commit     = (state_reg == S_W3) && payload;
    end

    // Latch the header direction and the first two payload words.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_reg       <= 1'b0;
            duration_reg  <= '0;
            increment_reg <= '0;
        end else begin
            if (move_hdr) begin
                dir_reg <= word_data[0];
            end
            if (payload && state_reg == S_W1) begin
                duration_reg <= word_data;
            end
            if (payload && state_reg == S_W2) begin
                increment_reg <= word_data;
            end
        end
    end

    // Push/pop decisions and next pointers. A commit into a full FIFO is
    // still accepted when the head is popped on the same edge.
    always_comb begin
        pop         = move_valid_reg & move_ready;
        full_int    = ((wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR);
        push        = commit & (~full_int | pop);
        wr_ptr_next = wr_ptr_reg + {{BUFFER_BITS{1'b0}}, push};
        rd_ptr_next = rd_ptr_reg + {{BUFFER_BITS{1'b0}}, pop};
        // Compare against the pre-push write pointer: a record written on
        // this edge is not readable until the following one (no bypass).
        head_valid_next = (wr_ptr_reg != rd_ptr_next);
    end

    assign wr_addr      = wr_ptr_reg[BUFFER_BITS-1:0];
    assign rd_addr_next = rd_ptr_next[BUFFER_BITS-1:0];

    // FIFO pointers, head-valid flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            move_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            move_valid_reg <= head_valid_next;
            if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end else if (commit && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign field_wr[0] = duration_reg;
    assign field_wr[1] = increment_reg;
    assign field_wr[2] = word_data;

    // Direction storage: written on push, contents never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            dir_mem[wr_addr] <= dir_reg;
        end
    end

    // Direction head stage: registered read, holds when nothing is queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_head_reg <= 1'b0;
        end else if (head_valid_next) begin
            dir_head_reg <= dir_mem[rd_addr_next];
        end
    end

    // One storage array plus registered head stage per wide record field.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            logic [WORD_WIDTH-1:0] mem [DEPTH];
            logic [WORD_WIDTH-1:0] head_reg;

            // Field storage write on accepted push.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_addr] <= field_wr[gi];
                end
            end

            // Field head stage: registered read of the next head entry.
            always_ff @(posedge clk) begin
                if (reset) begin
                    head_reg <= '0;
                end else if (head_valid_next) begin
                    head_reg <= mem[rd_addr_next];
                end
            end

            assign field_head[gi] = head_reg;
        end
    endgenerate

    assign move_valid     = move_valid_reg;
    assign move_dir       = dir_head_reg;
    assign move_duration  = field_head[0];
    assign move_increment = field_head[1];
    assign move_incinc    = field_head[2];
    assign fill_count     = wr_ptr_reg - rd_ptr_reg;
    assign full           = full_int;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_move_queue.sv
// Testbench for move_queue: a directed vector table for a single move,
// hand-written corner-case sequences, and randomized traffic. Every cycle is
// compared against a record-level queue model of the block.
module tb_move_queue;

    localparam int BB    = 2;
    localparam int WW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          word_valid;
    logic [WW-1:0] word_data;
    logic          word_is_header;
    logic          move_valid;
    logic          move_ready;
    logic          move_dir;
    logic [WW-1:0] move_duration;
    logic [WW-1:0] move_increment;
    logic [WW-1:0] move_incinc;
    logic [BB:0]   fill_count;
    logic          full;
    logic          collecting;
    logic          overflow;
    logic          clear_overflow;

    always #5 clk = ~clk;

    move_queue #(.BUFFER_BITS(BB), .WORD_WIDTH(WW)) dut (
        .clk            (clk),
        .reset          (reset),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_is_header (word_is_header),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .move_dir       (move_dir),
        .move_duration  (move_duration),
        .move_increment (move_increment),
        .move_incinc    (move_incinc),
        .fill_count     (fill_count),
        .full           (full),
        .collecting     (collecting),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned edge_cnt = 0;

    // Reference model: a queue of whole records, each tagged with the edge
    // on which it was committed; payload words gathered in a list.
    typedef struct {
        logic          dir;
        logic [63:0]   dur;
        logic [63:0]   inc;
        logic [63:0]   incinc;
        int unsigned   edge_n;
    } rec_t;

    rec_t        mq[$];
    logic [63:0] pw[$];
    bit          m_coll  = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_valid = 1'b0;
    logic        pdir    = 1'b0;
    rec_t        shown   = '{1'b0, 64'd0, 64'd0, 64'd0, 0};

    typedef struct {
        logic        wv;
        logic        hdr;
        logic [63:0] data;
        logic        rdy;
        logic        e_valid;
        logic        e_dir;
        logic [63:0] e_dur;
        logic [63:0] e_inc;
        logic [63:0] e_incinc;
        logic [2:0]  e_fill;
        logic        e_coll;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs held at it.
    task automatic model_edge();
        bit   pop;
        bit   commit;
        rec_t r;
        if (reset) begin
            mq.delete();
            pw.delete();
            m_coll = 1'b0;
            m_ovf  = 1'b0;
            shown  = '{1'b0, 64'd0, 64'd0, 64'd0, 0};
            return;
        end
        pop    = m_valid && move_ready;
        commit = 1'b0;
        if (word_valid) begin
            if (word_is_header) begin
                pw.delete();
                m_coll = (word_data[63:56] == 8'h01);
                if (m_coll) pdir = word_data[0];
            end else if (m_coll) begin
                pw.push_back(word_data);
                if (pw.size() == 3) begin
                    commit = 1'b1;
                    m_coll = 1'b0;
                end
            end
        end
        if (pop) mq.delete(0);
        if (commit) begin
            if (mq.size() < DEPTH) begin
                r.dir    = pdir;
                r.dur    = pw[0];
                r.inc    = pw[1];
                r.incinc = pw[2];
                r.edge_n = edge_cnt;
                mq.push_back(r);
            end else begin
                m_ovf = 1'b1;
            end
            pw.delete();
        end
        if (clear_overflow) m_ovf = 1'b0;
    endtask

    // A record is visible once at least one edge has passed since its commit.
    task automatic compare_model();
        m_valid = (mq.size() > 0) && (mq[0].edge_n < edge_cnt);
        if (m_valid) shown = mq[0];
        chk("move_valid",     64'(move_valid),  64'(m_valid));
        chk("move_dir",       64'(move_dir),    64'(shown.dir));
        chk("move_duration",  move_duration,    shown.dur);
        chk("move_increment", move_increment,   shown.inc);
        chk("move_incinc",    move_incinc,      shown.incinc);
        chk("fill_count",     64'(fill_count),  64'(mq.size()));
        chk("full",           64'(full),        64'(mq.size() == DEPTH));
        chk("collecting",     64'(collecting),  64'(m_coll));
        chk("overflow",       64'(overflow),    64'(m_ovf));
    endtask

    task automatic cycle(input logic wv, input logic hdr, input logic [63:0] data,
                         input logic rdy, input logic clr);
        word_valid     = wv;
        word_is_header = hdr;
        word_data      = data;
        move_ready     = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
        edge_cnt++;
        model_edge();
        word_valid     = 1'b0;
        word_is_header = 1'b0;
        word_data      = '0;
        move_ready     = 1'b0;
        clear_overflow = 1'b0;
        compare_model();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic hdr, input logic [63:0] data);
        cycle(1'b1, hdr, data, 1'b0, 1'b0);
        idle();
    endtask

    task automatic send_move(input logic dir, input logic [63:0] dur, input logic [63:0] inc,
                             input logic [63:0] incinc, input logic last_rdy);
        send_word(1'b1, {8'h01, 55'd0, dir});
        send_word(1'b0, dur);
        send_word(1'b0, inc);
        cycle(1'b1, 1'b0, incinc, last_rdy, 1'b0);
        idle();
    endtask

    task automatic pop_one();
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        word_valid     = 1'b0;
        word_is_header = 1'b0;
        word_data      = '0;
        move_ready     = 1'b0;
        clear_overflow = 1'b0;

        // Single move: inputs for one edge, outputs expected after it.
        vt[0] = '{1'b1, 1'b1, 64'h0100000000000001, 1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd0, 1'b1};
        vt[1] = '{1'b0, 1'b0, 64'd0,                1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd0, 1'b1};
        vt[2] = '{1'b1, 1'b0, 64'd1000,             1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 64'd0,                1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd0, 1'b1};
        vt[4] = '{1'b1, 1'b0, 64'h10,               1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd0, 1'b1};
        vt[5] = '{1'b0, 1'b0, 64'd0,                1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd0, 1'b1};
        vt[6] = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0, 64'd0,    64'd0,  64'd0,                 3'd1, 1'b0};
        vt[7] = '{1'b0, 1'b0, 64'd0,                1'b0, 1'b1, 1'b1, 64'd1000, 64'h10, 64'hFFFFFFFFFFFFFFFE, 3'd1, 1'b0};
        vt[8] = '{1'b0, 1'b0, 64'd0,                1'b1, 1'b0, 1'b1, 64'd1000, 64'h10, 64'hFFFFFFFFFFFFFFFE, 3'd0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 64'd0,                1'b0, 1'b0, 1'b1, 64'd1000, 64'h10, 64'hFFFFFFFFFFFFFFFE, 3'd0, 1'b0};

        idle();
        idle();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].wv, vt[i].hdr, vt[i].data, vt[i].rdy, 1'b0);
            chk("tbl_valid",  64'(move_valid), 64'(vt[i].e_valid));
            chk("tbl_dir",    64'(move_dir),   64'(vt[i].e_dir));
            chk("tbl_dur",    move_duration,   vt[i].e_dur);
            chk("tbl_inc",    move_increment,  vt[i].e_inc);
            chk("tbl_incinc", move_incinc,     vt[i].e_incinc);
            chk("tbl_fill",   64'(fill_count), 64'(vt[i].e_fill));
            chk("tbl_coll",   64'(collecting), 64'(vt[i].e_coll));
        end

        // Fill: five moves without pops, fifth one dropped.
        for (int i = 1; i <= 5; i++) begin
            send_move(1'b0, 64'(i), 64'd0, 64'd0, 1'b0);
            if (i == 4) chk("fill_full4", 64'(full), 64'd1);
        end
        chk("fill_ovf",   64'(overflow),   64'd1);
        chk("fill_count", 64'(fill_count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("fill_order", move_duration, 64'(i));
            pop_one();
        end
        chk("fill_empty", 64'(move_valid), 64'd0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("ovf_clear", 64'(overflow), 64'd0);

        // Full FIFO with the commit coinciding with a pop.
        for (int i = 0; i < 4; i++) send_move(1'b1, 64'(11 + i), 64'd0, 64'd0, 1'b0);
        chk("fp_full", 64'(full), 64'd1);
        send_move(1'b0, 64'd15, 64'd0, 64'd0, 1'b1);
        chk("fp_ovf",  64'(overflow),   64'd0);
        chk("fp_fill", 64'(fill_count), 64'd4);
        for (int i = 12; i <= 15; i++) begin
            chk("fp_order", move_duration, 64'(i));
            pop_one();
        end
        chk("fp_last_dir", 64'(move_dir), 64'd0);

        // Aborted message: 0x03 header discards the partial record.
        send_word(1'b1, 64'h0100000000000000);
        send_word(1'b0, 64'd50);
        send_word(1'b1, 64'h0300000000000000);
        send_word(1'b0, 64'd51);
        send_word(1'b0, 64'd52);
        chk("abort_coll", 64'(collecting), 64'd0);
        chk("abort_fill", 64'(fill_count), 64'd0);

        // Restart: a second 0x01 header replaces the partial record.
        send_word(1'b1, 64'h0100000000000000);
        send_word(1'b0, 64'd60);
        send_word(1'b1, 64'h0100000000000001);
        send_word(1'b0, 64'd7);
        send_word(1'b0, 64'd8);
        send_word(1'b0, 64'd9);
        chk("restart_fill", 64'(fill_count), 64'd1);
        chk("restart_dir",  64'(move_dir),   64'd1);
        chk("restart_dur",  move_duration,   64'd7);
        pop_one();

        // Wrap: 20 records one at a time through the pointers.
        for (int i = 0; i < 20; i++) begin
            send_move(1'(i), 64'(100 + i), 64'(i), 64'(-i), 1'b0);
            chk("wrap_dur", move_duration, 64'(100 + i));
            chk("wrap_dir", 64'(move_dir), 64'(i % 2));
            pop_one();
        end
        chk("wrap_fill", 64'(fill_count), 64'd0);

        // Reset with records queued and a message half received.
        send_move(1'b1, 64'd200, 64'd1, 64'd2, 1'b0);
        send_move(1'b0, 64'd201, 64'd3, 64'd4, 1'b0);
        send_word(1'b1, 64'h0100000000000001);
        send_word(1'b0, 64'd202);
        chk("rst_pre_coll", 64'(collecting), 64'd1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("rst_valid",  64'(move_valid),  64'd0);
        chk("rst_dir",    64'(move_dir),    64'd0);
        chk("rst_dur",    move_duration,    64'd0);
        chk("rst_inc",    move_increment,   64'd0);
        chk("rst_incinc", move_incinc,      64'd0);
        chk("rst_fill",   64'(fill_count),  64'd0);
        chk("rst_full",   64'(full),        64'd0);
        chk("rst_coll",   64'(collecting),  64'd0);
        chk("rst_ovf",    64'(overflow),    64'd0);
        send_move(1'b1, 64'd300, 64'd5, 64'd6, 1'b0);
        chk("post_rst_valid", 64'(move_valid), 64'd1);
        chk("post_rst_dur",   move_duration,   64'd300);
        pop_one();

        // Randomized traffic, words spaced by at least one idle cycle.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [63:0] d;
            logic        rdy;
            logic        clr;
            r   = $urandom_range(0, 99);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            d   = {$urandom, $urandom};
            if (r < 2) begin
                reset = 1'b1;
                idle();
                reset = 1'b0;
            end else if (r < 22) begin
                if ($urandom_range(0, 4) != 0) d[63:56] = 8'h01;
                else if (d[63:56] == 8'h01) d[63:56] = 8'h02;
                cycle(1'b1, 1'b1, d, rdy, clr);
            end else if (r < 75) begin
                cycle(1'b1, 1'b0, d, rdy, clr);
            end else begin
                cycle(1'b0, 1'b0, 64'd0, rdy, clr);
            end
            cycle(1'b0, 1'b0, 64'd0, ($urandom_range(0, 2) == 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
